ifq: RTL and testbench
======================

# ifq

Instruction fetch queue between `ifu` and the decode stage. Captures each instruction word and its address from the fetch unit and presents them in program order to decode over a valid/ready handshake. Drives `ifu`'s `pause` input to provide back-pressure, and discards all queued entries on a jump/flush.

## Interface

- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `clk`  input  1  system clock; all state updates on posedge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  `ifu` presents a fetched instruction this cycle.
- `in_inst`  input  `XLEN_WIDTH` (32)  instruction word from `ifu` `inst`.
- `in_addr`  input  `XLEN_WIDTH` (32)  instruction address from `ifu` `inst_addr`.
- `pause`  output  1  back-pressure to `ifu` `pause`.
- `flush`  input  1  jump taken; same signal that drives `ifu` `jump`.
- `out_valid`  output  1  head entry valid for decode.
- `out_inst`  output  `XLEN_WIDTH`  head instruction word.
- `out_addr`  output  `XLEN_WIDTH`  head instruction address.
- `out_ready`  input  1  decode accepts the head entry this cycle.

## Operation

- Storage:
  - `DEPTH` entries of {inst, addr}.
  - Read pointer and write pointer, each log2(`DEPTH`) bits, wrap modulo `DEPTH`.
  - `count`, log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
- Pop (`pop`) = `out_valid && out_ready && !flush`.
  - Advances the read pointer.
  - Decrements `count`.
- Push (`push`) = `in_valid && !flush && (count < DEPTH || pop)`.
  - Writes at the write pointer.
  - Advances the write pointer.
  - Increments `count`.
- Push and pop in the same cycle:
  - Both pointers advance.
  - `count` is unchanged.
  - Legal when full and when empty.
- Push attempted while full with no pop: dropped, no state change. This is a protocol violation; `pause` prevents it.
- `pause` = `count >= DEPTH-1`. It depends only on registered state, so there is no combinational path from `in_valid` or `out_ready`. The one-slot margin absorbs the one instruction `ifu` already has in flight when it sees `pause`.
- Head outputs:
  - `out_valid` = `(count != 0) && !flush`.
  - `out_inst` and `out_addr` = entry at the read pointer (combinational read of registered storage).
- Flush:
  - At the next edge, `count` and both pointers are cleared to 0.
  - A concurrent `in_valid` is discarded.
  - A concurrent `out_ready` does not pop.
- Reset values (asserted asynchronously):
  - `count` 0, both pointers 0, all storage 0.
  - Therefore `out_valid` 0, `out_inst` 0, `out_addr` 0, `pause` 0.
- Reset asserted mid-stream: every entry is lost immediately; no partial state survives.

## Timing

- Push to `out_valid` latency is 1 cycle: an entry pushed at edge N is visible after edge N and can be popped in cycle N+1.
- Throughput is 1 instruction per cycle when `out_ready` is held high.
- `pause` rises in the cycle after the push that brings `count` to `DEPTH-1`. It falls in the cycle after the pop that brings `count` below `DEPTH-1`.
- Flush drops `out_valid` in the same cycle (combinational). The queue is empty after the flush edge. The first post-jump instruction from `ifu` is pushed normally.
- `out_inst` and `out_addr` are stable while `out_valid && !out_ready`; the head does not change until it is popped.

## Configuration

- Macro `IFQ_BYPASS_EN`.
- Defined:
  - When `count == 0` and not flushing, `out_valid` = `in_valid`, and `out_inst`/`out_addr` = `in_inst`/`in_addr` combinationally.
  - If `out_ready` is also high, the entry is consumed without being written; pointers and `count` are unchanged. This gives 0-cycle latency through an empty queue.
  - If `out_ready` is low, the entry is pushed normally.
- Undefined: 1-cycle latency always; no combinational path from input to output.

## Test plan

- Reset, then `in_valid`=1 with inst 0x00000093 at addr 0x0, `out_ready`=1:
  - Without bypass: `out_valid`=1 one cycle later with addr 0x0.
  - With `IFQ_BYPASS_EN`: same cycle, with `count` staying 0.
- `out_ready`=0 while pushing addrs 0x0, 0x4, 0x8:
  - `pause`=1 after the third push (`DEPTH`=4).
  - A fourth push at 0xC is accepted, `count`=4.
  - A fifth is dropped.
  - Releasing `out_ready` drains 0x0, 0x4, 0x8, 0xC in order.
- Continuous push/pop with `out_ready`=1 over 10 instructions:
  - One pop per cycle, addresses increase by 4, with pointer wrap-around exercised.
  - `pause` stays 0.
- Queue holding 3 entries, `flush`=1 with `in_valid`=1 and `out_ready`=1:
  - `out_valid`=0 that cycle.
  - Next cycle `count`=0, the pushed entry is absent, and no pop occurred.
- Asynchronous `rst` pulse mid-cycle with 2 entries queued:
  - `out_valid`, `out_inst`, `out_addr` and `pause` go to 0 immediately, without waiting for a clock edge.
- Full queue, simultaneous push and pop:
  - `count` stays 4.
  - Head advances by one entry.
  - New entry lands at the tail.

Source files
------------

// File: rtl/ifq.sv
`default_nettype none
// ============================================================================
// Module   : ifq
// Brief    : Instruction fetch queue between ifu and decode. Optional
//            zero-latency bypass through an empty queue via IFQ_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifq #(
    parameter int DEPTH      = 4,
    parameter int XLEN_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [XLEN_WIDTH-1:0] in_inst,
    input  logic [XLEN_WIDTH-1:0] in_addr,
    output logic                  pause,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [XLEN_WIDTH-1:0] out_inst,
    output logic [XLEN_WIDTH-1:0] out_addr,
    input  logic                  out_ready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_full      = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_pause_lvl = c_cnt_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

    logic [XLEN_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [XLEN_WIDTH-1:0] r_addr_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_bypass;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full);

    // Only a stored head can be popped; a bypassed entry never touches state.
    assign w_pop   = !w_empty && out_ready && !flush;

`ifdef IFQ_BYPASS_EN
    assign w_bypass  = w_empty && in_valid && out_ready && !flush;
    assign out_valid = (!w_empty || in_valid) && !flush;
    assign out_inst  = w_empty ? in_inst : r_inst_mem[r_rd_ptr];
    assign out_addr  = w_empty ? in_addr : r_addr_mem[r_rd_ptr];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty && !flush;
    assign out_inst  = r_inst_mem[r_rd_ptr];
    assign out_addr  = r_addr_mem[r_rd_ptr];
`endif

    assign w_push = in_valid && !flush && (!w_full || w_pop) && !w_bypass;

    // Registered-only source keeps in_valid/out_ready off the ifu pause path.
    assign pause = (r_count >= c_pause_lvl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_addr_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_inst_mem[r_wr_ptr] <= in_inst;
            r_addr_mem[r_wr_ptr] <= in_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifq
// Brief    : Self-checking bench for ifq using an expected-entry scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifq;

    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_addr;
    logic        pause;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_ready;

    logic [63:0] sbq [$];
    int          mcount;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    ifq #(
        .DEPTH      (DEPTH),
        .XLEN_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_addr   (in_addr),
        .pause     (pause),
        .flush     (flush),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_ready (out_ready)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h0000_0093;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model.
    task automatic step(input logic v, input logic [31:0] a, input logic rdy, input logic fl);
        logic [63:0] head_exp;
        bit          exp_valid;
        bit          pop;
        bit          byp;
        bit          push;
        in_valid  = v;
        in_inst   = inst_of(a);
        in_addr   = a;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        byp       = c_byp && (mcount == 0) && v && rdy && !fl;
        exp_valid = !fl && ((mcount != 0) || (c_byp && v));
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
        chk("pause", {63'd0, pause}, {63'd0, (mcount >= DEPTH - 1)});
        if (exp_valid) begin
            head_exp = (mcount != 0) ? sbq[0] : {inst_of(a), a};
            chk("head", {out_inst, out_addr}, head_exp);
        end
        pop  = (mcount != 0) && rdy && !fl;
        push = v && !fl && ((mcount < DEPTH) || pop) && !byp;
        if (fl) begin
            sbq.delete();
            mcount = 0;
        end else begin
            if (pop) begin
                void'(sbq.pop_front());
                mcount--;
            end
            if (push) begin
                sbq.push_back({inst_of(a), a});
                mcount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_addr   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        mcount    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
        chk("rst_out_addr", {32'd0, out_addr}, 64'd0);
        chk("rst_pause", {63'd0, pause}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First instruction latency
        step(1'b1, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: fill, overflow attempt, drain in order
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming with pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with concurrent push and ready
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'h208, 1'b0, 1'b0);
        step(1'b1, 32'h20C, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h300, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges
        step(1'b1, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h404, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_inst", {32'd0, out_inst}, 64'd0);
        chk("arst_out_addr", {32'd0, out_addr}, 64'd0);
        chk("arst_pause", {63'd0, pause}, 64'd0);
        rst = 1'b0;
        sbq.delete();
        mcount = 0;
        @(posedge clk);
        #1;
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h510, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
